// File: rtl/dcache_pkg.sv
// ============================================================================
//  Module   : dcache_pkg
//  Purpose  : Shared field widths, FSM encoding, beat constants, reset values
//             and address helpers for the direct-mapped data cache.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

   localparam int INDEX_W = 5;
   localparam int OFF_W   = 2;
   localparam int WORD_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int TAG_W   = 15 - OFF_W - INDEX_W;
   localparam int LINES   = 2 ** INDEX_W;
   localparam int BEATS   = 2 ** OFF_W;
   localparam int LINE_W  = BEATS * WORD_W;

   localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(BEATS - 1);
   localparam logic [WORD_W-1:0] RST_WORD  = '0;
   localparam logic [ADDR_W-1:0] RST_ADDR  = '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WB   = 2'd1,
      S_FILL = 2'd2,
      S_RESP = 2'd3
   } state_e;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return a[OFF_W+1 +: INDEX_W];
   endfunction

   function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
      return a[1 +: OFF_W];
   endfunction

   // Word-aligned address of beat 0 of the line containing a
   function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};
   endfunction

   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] l,
                                                   input logic [OFF_W-1:0]  o);
      return l[int'(o)*WORD_W +: WORD_W];
   endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// ============================================================================
//  Module   : dcache_array
//  Purpose  : Tag/valid/dirty/data storage for the data cache. Whole-line
//             asynchronous read, synchronous word and metadata writes,
//             valid/dirty cleared asynchronously by the active-low reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_array
   import dcache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_idx_i,
   output logic               rd_valid_o,
   output logic               rd_dirty_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output logic [LINE_W-1:0]  rd_line_o,
   input  logic [INDEX_W-1:0] wr_idx_i,
   input  logic               word_we_i,
   input  logic [OFF_W-1:0]   word_off_i,
   input  logic [WORD_W-1:0]  word_data_i,
   input  logic               meta_we_i,
   input  logic               meta_valid_i,
   input  logic               meta_dirty_i,
   input  logic [TAG_W-1:0]   meta_tag_i
);

   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  dirty_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [WORD_W-1:0] data_q [LINES][BEATS];

   // Line state bits: cleared on reset so every line starts invalid and clean
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (meta_we_i) begin
         valid_q[wr_idx_i] <= meta_valid_i;
         dirty_q[wr_idx_i] <= meta_dirty_i;
      end
   end

   // Tag and data contents need no reset: they are only trusted when valid
   always_ff @(posedge clk) begin
      if (meta_we_i) tag_q[wr_idx_i] <= meta_tag_i;
      if (word_we_i) data_q[wr_idx_i][word_off_i] <= word_data_i;
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];

   for (genvar b = 0; b < BEATS; b++) begin : g_line
      assign rd_line_o[b*WORD_W +: WORD_W] = data_q[rd_idx_i][b];
   end

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
//  Module   : dcache_ctrl
//  Purpose  : Direct-mapped, write-back, write-allocate data cache responder
//             for the MEM stage. Hits complete in the request cycle; misses
//             run a 4-beat write-back (dirty victim) and a 4-beat fill.
//  Config   : DCACHE_STATS_EN builds saturating hit/miss counters; without
//             it hit_cnt/miss_cnt are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        Err,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);

   state_e             state_q;
   logic [OFF_W-1:0]   beat_q;
   logic [15:0]        addr_q;
   logic [15:0]        st_data_q;
   logic               wr_q;
   logic               abandon_q;
   logic [15:0]        mem_addr_q;
   logic [15:0]        mem_wdata_q;
   logic               mem_rd_q;
   logic               mem_wr_q;

   logic               w_valid;
   logic               w_dirty;
   logic [TAG_W-1:0]   w_tag;
   logic [LINE_W-1:0]  w_line;
   logic [INDEX_W-1:0] w_arr_idx;
   logic               w_word_we;
   logic [OFF_W-1:0]   w_word_off;
   logic [WORD_W-1:0]  w_word_data;
   logic               w_meta_we;
   logic               w_meta_dirty;
   logic [TAG_W-1:0]   w_meta_tag;

   // Request decode; everything is forced quiet while reset is asserted
   logic w_req, w_idle, w_err_c, w_tag_hit, w_hit, w_miss, w_resp_done, w_merge;
   assign w_req       = Rd | Wr;
   assign w_idle      = (state_q == S_IDLE);
   assign w_err_c     = w_req & (Addr[0] | (Rd & Wr));
   assign w_tag_hit   = w_valid & (w_tag == addr_tag(Addr));
   assign w_hit       = rst & w_idle & w_req & ~w_err_c & w_tag_hit;
   assign w_miss      = rst & w_idle & w_req & ~w_err_c & ~w_tag_hit;
   assign w_resp_done = rst & (state_q == S_RESP) & w_req & ~abandon_q;
   // The store is merged only if the pipeline is still waiting for it
   assign w_merge     = wr_q & ~abandon_q & Wr;

   assign Err      = rst & w_idle & w_err_c;
   assign CacheHit = w_hit;
   assign Done     = Err | w_hit | w_resp_done;
   assign Stall    = rst & w_req & ~Done;
   assign DataOut  = (w_hit & Rd)          ? line_word(w_line, addr_off(Addr))   :
                     (w_resp_done & ~wr_q) ? line_word(w_line, addr_off(addr_q)) :
                                             RST_WORD;

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;

   // Idle looks at the incoming address; a miss in flight works on its latched copy
   assign w_arr_idx = w_idle ? addr_idx(Addr) : addr_idx(addr_q);

   dcache_array u_array (
      .clk          (clk),
      .rst          (rst),
      .rd_idx_i     (w_arr_idx),
      .rd_valid_o   (w_valid),
      .rd_dirty_o   (w_dirty),
      .rd_tag_o     (w_tag),
      .rd_line_o    (w_line),
      .wr_idx_i     (w_arr_idx),
      .word_we_i    (w_word_we),
      .word_off_i   (w_word_off),
      .word_data_i  (w_word_data),
      .meta_we_i    (w_meta_we),
      .meta_valid_i (1'b1),
      .meta_dirty_i (w_meta_dirty),
      .meta_tag_i   (w_meta_tag)
   );

   // Array write steering: hit stores, fill beats, and line install in RESP
   always_comb begin
      w_word_we    = 1'b0;
      w_word_off   = addr_off(Addr);
      w_word_data  = DataIn;
      w_meta_we    = 1'b0;
      w_meta_dirty = 1'b0;
      w_meta_tag   = addr_tag(Addr);
      case (state_q)
         S_IDLE: begin
            if (w_hit && Wr) begin
               w_word_we    = 1'b1;
               w_meta_we    = 1'b1;
               w_meta_dirty = 1'b1;
            end
         end
         S_FILL: begin
            if (mem_rd_q && mem_ack) begin
               w_word_we   = 1'b1;
               w_word_off  = beat_q;
               w_word_data = mem_rdata;
            end
         end
         S_RESP: begin
            w_meta_we    = 1'b1;
            w_meta_tag   = addr_tag(addr_q);
            w_meta_dirty = w_merge;
            w_word_we    = w_merge;
            w_word_off   = addr_off(addr_q);
            w_word_data  = st_data_q;
         end
         default: ;
      endcase
   end

   // Miss sequencer: write-back beats, fill beats, one response cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         addr_q      <= RST_ADDR;
         st_data_q   <= RST_WORD;
         wr_q        <= 1'b0;
         abandon_q   <= 1'b0;
         mem_addr_q  <= RST_ADDR;
         mem_wdata_q <= RST_WORD;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_miss) begin
                  addr_q    <= Addr;
                  st_data_q <= DataIn;
                  wr_q      <= Wr;
                  abandon_q <= 1'b0;
                  beat_q    <= '0;
                  if (w_valid && w_dirty) begin
                     state_q     <= S_WB;
                     mem_wr_q    <= 1'b1;
                     mem_addr_q  <= {w_tag, addr_idx(Addr), {(OFF_W+1){1'b0}}};
                     mem_wdata_q <= line_word(w_line, '0);
                  end else begin
                     state_q    <= S_FILL;
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= line_base(Addr);
                  end
               end
            end
            S_WB: begin
               if (!w_req) abandon_q <= 1'b1;
               if (mem_wr_q && mem_ack) begin
                  if (beat_q == LAST_BEAT) begin
                     state_q    <= S_FILL;
                     beat_q     <= '0;
                     mem_wr_q   <= 1'b0;
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= line_base(addr_q);
                  end else begin
                     beat_q      <= beat_q + 1'b1;
                     mem_addr_q  <= mem_addr_q + 16'd2;
                     mem_wdata_q <= line_word(w_line, beat_q + 1'b1);
                  end
               end
            end
            S_FILL: begin
               if (!w_req) abandon_q <= 1'b1;
               if (mem_rd_q && mem_ack) begin
                  if (beat_q == LAST_BEAT) begin
                     state_q  <= S_RESP;
                     beat_q   <= '0;
                     mem_rd_q <= 1'b0;
                  end else begin
                     beat_q     <= beat_q + 1'b1;
                     mem_addr_q <= mem_addr_q + 16'd2;
                  end
               end
            end
            S_RESP: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] hit_cnt_q;
   logic [15:0] miss_cnt_q;

   // Saturating counts of completed non-error requests, split by hit/miss
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (Done && !Err) begin
         if (CacheHit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
         end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
         end
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   assign hit_cnt  = 16'd0;
   assign miss_cnt = 16'd0;
`endif

endmodule

`default_nettype wire
